port_arbiter: RTL and testbench
===============================

# port_arbiter

Two-requester arbiter and sequencer for the shared 8-bit I/O port bus, which carries CPU `IN`/`OUT` traffic to the keyboard and CGA register decoder. It accepts port read/write requests from requester 0 (CPU core) and requester 1 (debug/DMA master). It grants one request at a time with round-robin priority. It drives one `port_clk` strobe per transaction, waits a programmable number of cycles, captures the read byte, and returns a single-cycle acknowledge to the granted requester.

## Interface
Parameters:
- `WAIT_STATES`, default 0: extra cycles between the strobe and the capture cycle; legal range 0–15.

Ports:
- `clock`  in  1  host clock. The block uses one clock only.
- `reset`  in  1  asynchronous, active-high reset.
- `r0_req`, `r1_req`  in  1  request. Held high, with the fields below stable, until the matching ack.
- `r0_addr`, `r1_addr`  in  16  port address.
- `r0_wdata`, `r1_wdata`  in  8  write byte.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read.
- `r0_ack`, `r1_ack`  out  1  one-cycle completion pulse.
- `r0_rdata`, `r1_rdata`  out  8  read result. Valid when ack is high; holds until the next read by the same requester.
- `port_clk`  out  1  one-cycle transaction strobe to the device bus.
- `port`  out  16  bus address.
- `port_o`  out  8  bus write data.
- `port_w`  out  1  bus write enable.
- `port_i`  in  8  bus read data. Devices register it on the edge that samples `port_clk`.
- `busy`  out  1  high while a transaction is in flight (all states except IDLE).
- `grant`  out  1  index of the current or last granted requester.

## Operation
- FSM states: IDLE → ISSUE → WAIT (W cycles; skipped when W = 0) → CAPTURE → IDLE.
- **IDLE**:
  - Eligible requester k: `rk_req=1` and `rk_ack=0`. The ack mask prevents re-granting a request whose ack is visible this cycle.
  - One eligible requester: grant it.
  - Both eligible: grant the requester ≠ `last_grant`.
  - On grant: latch addr, wdata and we into `port`, `port_o`, `port_w`; set `grant`; update `last_grant`; go to ISSUE.
- **ISSUE**: `port_clk=1` for exactly this cycle. The bus fields stay latched. Load the wait counter with `WAIT_STATES`.
- **WAIT**: count down. Exit to CAPTURE when the counter reaches 0. `port_clk=0`.
- **CAPTURE**:
  - Read: `r{grant}_rdata <= port_i`.
  - Write: rdata is left unchanged.
  - Always: `r{grant}_ack <= 1`; go to IDLE.
- Ack is a registered pulse. It is cleared the following cycle unconditionally.
- If the requester drops `req` mid-transaction, the transaction still completes and ack is still issued. Fields are latched at grant, so later input changes are ignored.
- `port`, `port_o` and `port_w` hold their last values after completion; only `port_clk` qualifies them.
- Reset values:
  - All outputs 0: `port_clk`, `port`, `port_o`, `port_w`, both acks, both rdata, `busy`, `grant`.
  - State IDLE, `last_grant=1`, so requester 0 wins the first tie.
- Reset mid-transaction: abort immediately. `port_clk` drops asynchronously, no ack is issued, and the aborted request is not replayed.

## Timing
- Request sampled in IDLE at cycle N:
  - ISSUE (`port_clk` high): N+1.
  - WAIT: N+2 … N+1+W.
  - CAPTURE: N+2+W.
  - Ack high with valid rdata: N+3+W.
- Latency from sampled request to ack is 3+W cycles.
- `busy` is high from N+1 through N+2+W.
- The ack cycle is IDLE, so a new grant can be sampled in the ack cycle. The acked requester is masked for that cycle.
- Back-to-back throughput:
  - Alternating requesters: one transaction every 3+W cycles.
  - Same requester holding `req` with new fields in the cycle after ack: one transaction every 4+W cycles.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0, 1, 0, 1.
- `port_clk` is never high on two consecutive cycles. It is never high while `busy` was already high on the previous cycle.

## Test plan
- W=0, `r0` reads 0x60 with the device returning 0x9C: `port_clk` pulses once at N+1 with `port=0x0060` and `port_w=0`; `r0_ack` is high at N+3 with `r0_rdata=0x9C`; `r1_ack` stays 0.
- Both requesters request at reset release (`r0` writes 0x3D4 ← 0x0E, `r1` reads 0x64): `r0` is served first; `r1`'s strobe follows at N+4; `grant` goes 0 → 1; `r0_rdata` is unchanged by the write.
- Both hold `req` continuously for 6 transactions: grants alternate 0, 1, 0, 1, 0, 1; strobes are spaced exactly 3 cycles apart; no double-grant in an ack cycle.
- WAIT_STATES=3, `r1` reads 0x3D5 with `port_i` changing to 0x12 only on the last wait cycle: ack at N+6; `r1_rdata=0x12`; `busy` high for 5 cycles.
- Assert `reset` during WAIT (W=3): all outputs go to 0 asynchronously; no ack follows; after release, a fresh tie is granted to `r0`.
- `r0` drops `req` the cycle after grant: the strobe and ack still occur on schedule, and the next IDLE grants no one.

Source files
------------

// File: rtl/port_arbiter.sv
// port_arbiter
//
// Two-requester round-robin arbiter and sequencer for the shared 8-bit I/O
// port bus. One request is granted at a time. Each transaction gets a single
// port_clk strobe, an optional run of wait states and a capture cycle, and
// ends with a single-cycle ack to the requester that was granted.
//
// Parameters
//   WAIT_STATES  extra cycles between the strobe and the capture cycle (0..15)
//
// Ports
//   clock                 host clock
//   reset                 asynchronous, active-high reset
//   r0_req / r1_req       request, held with stable fields until the matching ack
//   r0_addr / r1_addr     16-bit port address
//   r0_wdata / r1_wdata   write byte
//   r0_we / r1_we         1 = write, 0 = read
//   r0_ack / r1_ack       one-cycle completion pulse
//   r0_rdata / r1_rdata   read result, held until the next read by that requester
//   port_clk              one-cycle transaction strobe to the device bus
//   port                  bus address
//   port_o                bus write data
//   port_w                bus write enable
//   port_i                bus read data
//   busy                  high in every state except IDLE
//   grant                 index of the current or last granted requester
//
// State table
//   state      | meaning
//   S_IDLE     | arbitrate; on a grant, latch the bus fields and raise port_clk
//   S_ISSUE    | port_clk high on the bus this cycle; load the wait counter
//   S_WAIT     | count down the wait states
//   S_CAPTURE  | sample port_i for reads, raise the ack of the granted requester

module port_arbiter #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        r0_req,
    input  logic [15:0] r0_addr,
    input  logic [7:0]  r0_wdata,
    input  logic        r0_we,
    output logic        r0_ack,
    output logic [7:0]  r0_rdata,

    input  logic        r1_req,
    input  logic [15:0] r1_addr,
    input  logic [7:0]  r1_wdata,
    input  logic        r1_we,
    output logic        r1_ack,
    output logic [7:0]  r1_rdata,

    output logic        port_clk,
    output logic [15:0] port,
    output logic [7:0]  port_o,
    output logic        port_w,
    input  logic [7:0]  port_i,

    output logic        busy,
    output logic        grant
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("port_arbiter: WAIT_STATES must be in 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // The counter is loaded with W-1 so that the terminal compare against 0
    // falls on the W-th wait cycle.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic       SKIP_WAIT = (WAIT_STATES == 0);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        last_grant;

    logic        elig0;
    logic        elig1;
    logic        any_elig;
    logic        pick;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_we;

    // A requester whose ack is visible this cycle is still holding req from
    // the transaction that just finished; masking it stops a double grant.
    always_comb begin
        elig0    = r0_req & ~r0_ack;
        elig1    = r1_req & ~r1_ack;
        any_elig = elig0 | elig1;
        if (elig0 && elig1) begin
            pick = ~last_grant;
        end else begin
            pick = elig1;
        end
    end

    always_comb begin
        sel_addr  = r0_addr;
        sel_wdata = r0_wdata;
        sel_we    = r0_we;
        if (pick) begin
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
            sel_we    = r1_we;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            port       <= 16'd0;
            port_o     <= 8'd0;
            port_w     <= 1'b0;
            port_clk   <= 1'b0;
            busy       <= 1'b0;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            r0_rdata   <= 8'd0;
            r1_rdata   <= 8'd0;
        end else begin
            // Strobe and acks are single-cycle pulses.
            port_clk <= 1'b0;
            r0_ack   <= 1'b0;
            r1_ack   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_elig) begin
                        port       <= sel_addr;
                        port_o     <= sel_wdata;
                        port_w     <= sel_we;
                        grant      <= pick;
                        last_grant <= pick;
                        port_clk   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    if (SKIP_WAIT) begin
                        state <= S_CAPTURE;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                S_CAPTURE: begin
                    if (!port_w) begin
                        if (grant) begin
                            r1_rdata <= port_i;
                        end else begin
                            r0_rdata <= port_i;
                        end
                    end
                    if (grant) begin
                        r1_ack <= 1'b1;
                    end else begin
                        r0_ack <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_arbiter.sv
// Testbench for port_arbiter. Two instances run side by side: A with no wait
// states and B with three. Stimulus pushes expected strobes and acks into
// per-instance queues; a negedge monitor pops and compares whenever a DUT
// presents port_clk or an ack.

module tb_port_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int busy_cnt_b = 0;

    // ---------------- instance A (WAIT_STATES = 0)
    logic        a_reset;
    logic        a_r0_req, a_r0_we, a_r0_ack, a_r1_req, a_r1_we, a_r1_ack;
    logic [15:0] a_r0_addr, a_r1_addr, a_port;
    logic [7:0]  a_r0_wdata, a_r1_wdata, a_r0_rdata, a_r1_rdata, a_port_o, a_port_i;
    logic        a_port_clk, a_port_w, a_busy, a_grant;

    // ---------------- instance B (WAIT_STATES = 3)
    logic        b_reset;
    logic        b_r0_req, b_r0_we, b_r0_ack, b_r1_req, b_r1_we, b_r1_ack;
    logic [15:0] b_r0_addr, b_r1_addr, b_port;
    logic [7:0]  b_r0_wdata, b_r1_wdata, b_r0_rdata, b_r1_rdata, b_port_o, b_port_i;
    logic        b_port_clk, b_port_w, b_busy, b_grant;

    port_arbiter #(.WAIT_STATES(0)) dut_a (
        .clock(clock), .reset(a_reset),
        .r0_req(a_r0_req), .r0_addr(a_r0_addr), .r0_wdata(a_r0_wdata), .r0_we(a_r0_we),
        .r0_ack(a_r0_ack), .r0_rdata(a_r0_rdata),
        .r1_req(a_r1_req), .r1_addr(a_r1_addr), .r1_wdata(a_r1_wdata), .r1_we(a_r1_we),
        .r1_ack(a_r1_ack), .r1_rdata(a_r1_rdata),
        .port_clk(a_port_clk), .port(a_port), .port_o(a_port_o), .port_w(a_port_w),
        .port_i(a_port_i), .busy(a_busy), .grant(a_grant)
    );

    port_arbiter #(.WAIT_STATES(3)) dut_b (
        .clock(clock), .reset(b_reset),
        .r0_req(b_r0_req), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata), .r0_we(b_r0_we),
        .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
        .r1_req(b_r1_req), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata), .r1_we(b_r1_we),
        .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
        .port_clk(b_port_clk), .port(b_port), .port_o(b_port_o), .port_w(b_port_w),
        .port_i(b_port_i), .busy(b_busy), .grant(b_grant)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] port;
        logic [7:0]  wd;
        logic        we;
        logic        gnt;
    } strobe_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        who;
        logic [7:0]  rdata;
    } ack_t;

    strobe_t sq_a[$];
    strobe_t sq_b[$];
    ack_t    aq_a[$];
    ack_t    aq_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_strobe(input int inst, input int c, input logic [15:0] p,
                              input logic [7:0] wd, input logic we, input logic g);
        strobe_t s;
        s.cyc = 32'(c); s.port = p; s.wd = wd; s.we = we; s.gnt = g;
        if (inst == 0) sq_a.push_back(s);
        else           sq_b.push_back(s);
    endtask

    task automatic exp_ack(input int inst, input int c, input logic who, input logic [7:0] rd);
        ack_t a;
        a.cyc = 32'(c); a.who = who; a.rdata = rd;
        if (inst == 0) aq_a.push_back(a);
        else           aq_b.push_back(a);
    endtask

    task automatic mon(input int inst, input logic pclk, input logic [15:0] p,
                       input logic [7:0] po, input logic pw, input logic g,
                       input logic a0, input logic a1,
                       input logic [7:0] d0, input logic [7:0] d1);
        strobe_t s;
        ack_t    a;
        string   tag;
        int      n;
        tag = (inst == 0) ? "A" : "B";
        if (pclk) begin
            n = (inst == 0) ? sq_a.size() : sq_b.size();
            if (n == 0) begin
                total++;
                bad++;
                $display("FAIL %s_strobe_unexpected: got strobe port=0x%0h at cycle %0d, expected none",
                         tag, p, cyc);
            end else begin
                if (inst == 0) s = sq_a.pop_front();
                else           s = sq_b.pop_front();
                chk({tag, "_strobe_cycle"}, 32'(cyc), s.cyc);
                chk({tag, "_strobe_port"}, {16'd0, p}, {16'd0, s.port});
                chk({tag, "_strobe_we"}, {31'd0, pw}, {31'd0, s.we});
                chk({tag, "_strobe_wdata"}, {24'd0, po}, {24'd0, s.wd});
                chk({tag, "_strobe_grant"}, {31'd0, g}, {31'd0, s.gnt});
            end
        end
        if (a0 || a1) begin
            n = (inst == 0) ? aq_a.size() : aq_b.size();
            if (n == 0) begin
                total++;
                bad++;
                $display("FAIL %s_ack_unexpected: got acks=%b%b at cycle %0d, expected none",
                         tag, a1, a0, cyc);
            end else begin
                if (inst == 0) a = aq_a.pop_front();
                else           a = aq_b.pop_front();
                chk({tag, "_ack_cycle"}, 32'(cyc), a.cyc);
                chk({tag, "_ack_who"}, {30'd0, a1, a0}, a.who ? 32'd2 : 32'd1);
                chk({tag, "_ack_rdata"}, {24'd0, (a.who ? d1 : d0)}, {24'd0, a.rdata});
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, a_port_clk, a_port, a_port_o, a_port_w, a_grant, a_r0_ack, a_r1_ack, a_r0_rdata, a_r1_rdata);
        mon(1, b_port_clk, b_port, b_port_o, b_port_w, b_grant, b_r0_ack, b_r1_ack, b_r0_rdata, b_r1_rdata);
        if (b_busy) busy_cnt_b++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic reset_chk(input int inst, input string name);
        if (inst == 0) begin
            chk({name, "_bus"}, {4'd0, a_port_clk, a_port_w, a_busy, a_grant, a_port_o, a_port}, 32'd0);
            chk({name, "_req"}, {14'd0, a_r0_ack, a_r1_ack, a_r0_rdata, a_r1_rdata}, 32'd0);
        end else begin
            chk({name, "_bus"}, {4'd0, b_port_clk, b_port_w, b_busy, b_grant, b_port_o, b_port}, 32'd0);
            chk({name, "_req"}, {14'd0, b_r0_ack, b_r1_ack, b_r0_rdata, b_r1_rdata}, 32'd0);
        end
    endtask

    int n;

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_r0_req = 0; a_r0_we = 0; a_r0_addr = 0; a_r0_wdata = 0;
        a_r1_req = 0; a_r1_we = 0; a_r1_addr = 0; a_r1_wdata = 0;
        b_r0_req = 0; b_r0_we = 0; b_r0_addr = 0; b_r0_wdata = 0;
        b_r1_req = 0; b_r1_we = 0; b_r1_addr = 0; b_r1_wdata = 0;
        a_port_i = 8'h00;
        b_port_i = 8'hFF;

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_chk(0, "A_reset");
        reset_chk(1, "B_reset");

        // Tie at reset release: r0 writes 0x3D4 <- 0x0E, r1 reads 0x64.
        step(1);
        n = cyc;
        a_reset = 1'b0; b_reset = 1'b0;
        a_r0_req = 1; a_r0_addr = 16'h03D4; a_r0_wdata = 8'h0E; a_r0_we = 1;
        a_r1_req = 1; a_r1_addr = 16'h0064; a_r1_wdata = 8'h00; a_r1_we = 0;
        a_port_i = 8'h5A;
        exp_strobe(0, n + 1, 16'h03D4, 8'h0E, 1'b1, 1'b0);
        exp_ack   (0, n + 3, 1'b0, 8'h00);
        exp_strobe(0, n + 4, 16'h0064, 8'h00, 1'b0, 1'b1);
        exp_ack   (0, n + 6, 1'b1, 8'h5A);
        step(3); a_r0_req = 0;
        step(3); a_r1_req = 0;

        // r0 alone reads 0x60, device returns 0x9C.
        step(1);
        n = cyc;
        a_port_i = 8'h9C;
        a_r0_req = 1; a_r0_addr = 16'h0060; a_r0_wdata = 8'h00; a_r0_we = 0;
        exp_strobe(0, n + 1, 16'h0060, 8'h00, 1'b0, 1'b0);
        exp_ack   (0, n + 3, 1'b0, 8'h9C);
        step(3); a_r0_req = 0;

        // r1 alone writes 0x61 <- 0xA5; its read byte stays 0x5A.
        step(1);
        n = cyc;
        a_r1_req = 1; a_r1_addr = 16'h0061; a_r1_wdata = 8'hA5; a_r1_we = 1;
        exp_strobe(0, n + 1, 16'h0061, 8'hA5, 1'b1, 1'b1);
        exp_ack   (0, n + 3, 1'b1, 8'h5A);
        step(3); a_r1_req = 0;

        // Both hold req for six transactions: strict alternation, 3-cycle spacing.
        step(1);
        n = cyc;
        a_port_i = 8'h33;
        a_r0_req = 1; a_r0_addr = 16'h0060; a_r0_wdata = 8'h00; a_r0_we = 0;
        a_r1_req = 1; a_r1_addr = 16'h0070; a_r1_wdata = 8'h77; a_r1_we = 1;
        for (int k = 0; k < 3; k++) begin
            exp_strobe(0, n + 1 + 6 * k, 16'h0060, 8'h00, 1'b0, 1'b0);
            exp_ack   (0, n + 3 + 6 * k, 1'b0, 8'h33);
            exp_strobe(0, n + 4 + 6 * k, 16'h0070, 8'h77, 1'b1, 1'b1);
            exp_ack   (0, n + 6 + 6 * k, 1'b1, 8'h5A);
        end
        step(15); a_r0_req = 0;
        step(3);  a_r1_req = 0;

        // r0 drops req the cycle after grant; transaction completes, no regrant.
        step(1);
        n = cyc;
        a_port_i = 8'hC3;
        a_r0_req = 1; a_r0_addr = 16'h0021; a_r0_wdata = 8'h00; a_r0_we = 0;
        exp_strobe(0, n + 1, 16'h0021, 8'h00, 1'b0, 1'b0);
        exp_ack   (0, n + 3, 1'b0, 8'hC3);
        step(1); a_r0_req = 0;
        step(5);
        chk("A_idle_busy", {31'd0, a_busy}, 32'd0);

        // B: r1 reads 0x3D5, port_i becomes 0x12 only on the last wait cycle.
        step(1);
        n = cyc;
        busy_cnt_b = 0;
        b_port_i = 8'hFF;
        b_r1_req = 1; b_r1_addr = 16'h03D5; b_r1_wdata = 8'h00; b_r1_we = 0;
        exp_strobe(1, n + 1, 16'h03D5, 8'h00, 1'b0, 1'b1);
        exp_ack   (1, n + 6, 1'b1, 8'h12);
        step(4); b_port_i = 8'h12;
        step(2); b_r1_req = 0;
        step(3);
        chk("B_busy_cycles", 32'(busy_cnt_b), 32'd5);

        // B: r0 read aborted by reset during WAIT; no ack may follow.
        step(1);
        n = cyc;
        b_port_i = 8'h55;
        b_r0_req = 1; b_r0_addr = 16'h0040; b_r0_wdata = 8'h00; b_r0_we = 0;
        exp_strobe(1, n + 1, 16'h0040, 8'h00, 1'b0, 1'b0);
        step(3);
        #1;
        b_reset = 1'b1;
        b_r0_req = 0;
        #1;
        reset_chk(1, "B_midreset");
        step(2);

        // Fresh tie after release goes to r0.
        n = cyc;
        b_reset = 1'b0;
        b_port_i = 8'h4E;
        b_r0_req = 1; b_r0_addr = 16'h0041; b_r0_wdata = 8'h00; b_r0_we = 0;
        b_r1_req = 1; b_r1_addr = 16'h0042; b_r1_wdata = 8'h00; b_r1_we = 0;
        exp_strobe(1, n + 1, 16'h0041, 8'h00, 1'b0, 1'b0);
        exp_ack   (1, n + 6, 1'b0, 8'h4E);
        exp_strobe(1, n + 7, 16'h0042, 8'h00, 1'b0, 1'b1);
        exp_ack   (1, n + 12, 1'b1, 8'h4E);
        step(6); b_r0_req = 0;
        step(6); b_r1_req = 0;
        step(4);

        chk("A_strobes_left", 32'(sq_a.size()), 32'd0);
        chk("A_acks_left",    32'(aq_a.size()), 32'd0);
        chk("B_strobes_left", 32'(sq_b.size()), 32'd0);
        chk("B_acks_left",    32'(aq_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
